// File: rtl/z1000_cfg_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z1000_cfg_loader_if                                                        |
// | Word stream, control and chain-side signals of the cfg loader.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface z1000_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              cfg_en;
    logic              cfg_d;
    logic              cfg_commit;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, cfg_en, cfg_d, cfg_commit, busy, done
    );

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, cfg_en, cfg_d, cfg_commit, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/z1000_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z1000_cfg_loader                                                           |
// | Serialises config words LSB-first into the dffe chain, then commits.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module z1000_cfg_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  wire logic          clk,
    input  wire logic          R,
    z1000_cfg_loader_if.slave  bus
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BCW    = $clog2(CHAIN_LEN + 1);
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int SCW    = $clog2(WORD_W + 1);

    localparam logic [BCW-1:0] CHAIN_LEN_C = BCW'(CHAIN_LEN);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(CHAIN_LEN - 1);
    localparam logic [WCW-1:0] NWORDS_C    = WCW'(NWORDS);
    localparam logic [SCW-1:0] WORD_BITS   = SCW'(WORD_W);
    localparam logic [SCW-1:0] ONE_BIT     = SCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [BCW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [WCW-1:0]    word_cnt_q,   word_cnt_d;
    logic [WORD_W-1:0] sh_q,         sh_d;
    logic [SCW-1:0]    sh_cnt_q,     sh_cnt_d;
    logic [WORD_W-1:0] hold_q,       hold_d;
    logic              hold_full_q,  hold_full_d;
    logic              cfg_en_q,     cfg_en_d;
    logic              cfg_d_q,      cfg_d_d;
    logic              cfg_commit_q, cfg_commit_d;
    logic              done_q,       done_d;
    logic              busy_q,       busy_d;

    logic              in_ready;
    logic              accept;
    logic              shift;
    logic              shifter_free;

    // in_ready depends on registered state only, never on in_valid.
    assign in_ready     = (state_q == ST_LOAD) && !hold_full_q && (word_cnt_q < NWORDS_C);
    assign accept       = bus.in_valid && in_ready;
    assign shift        = (state_q == ST_LOAD) && (sh_cnt_q != '0) && (bit_cnt_q < CHAIN_LEN_C);
    assign shifter_free = (sh_cnt_q == '0) || (shift && (sh_cnt_q == ONE_BIT));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        sh_d        = sh_q;
        sh_cnt_d    = sh_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_LOAD;
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                    sh_d        = '0;
                    sh_cnt_d    = '0;
                    hold_d      = '0;
                    hold_full_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (shift) begin
                    sh_d      = sh_q >> 1;
                    sh_cnt_d  = sh_cnt_q - ONE_BIT;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_COMMIT;
                    end
                end
                // Holding register refills the shifter on the edge it empties.
                if (shifter_free && hold_full_q) begin
                    sh_d        = hold_q;
                    sh_cnt_d    = WORD_BITS;
                    hold_full_d = 1'b0;
                end
                // in_ready implies the holding register is empty, so no clash above.
                if (accept) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (shifter_free) begin
                        sh_d     = bus.in_data;
                        sh_cnt_d = WORD_BITS;
                    end else begin
                        hold_d      = bus.in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            word_cnt_d  = '0;
            sh_d        = '0;
            sh_cnt_d    = '0;
            hold_d      = '0;
            hold_full_d = 1'b0;
        end

        // Registered outputs mirror what the next cycle's shift will present.
        cfg_en_d     = (state_d == ST_LOAD) && (sh_cnt_d != '0) && (bit_cnt_d < CHAIN_LEN_C);
        cfg_d_d      = cfg_en_d && sh_d[0];
        cfg_commit_d = (state_d == ST_COMMIT);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sh_q         <= '0;
            sh_cnt_q     <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cfg_en_q     <= 1'b0;
            cfg_d_q      <= 1'b0;
            cfg_commit_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sh_q         <= sh_d;
            sh_cnt_q     <= sh_cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cfg_en_q     <= cfg_en_d;
            cfg_d_q      <= cfg_d_d;
            cfg_commit_q <= cfg_commit_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.cfg_en     = cfg_en_q;
    assign bus.cfg_d      = cfg_d_q;
    assign bus.cfg_commit = cfg_commit_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_z1000_cfg_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_z1000_cfg_loader                                                        |
// | Directed bench: a 70-bit chain loader and a single-word 32-bit loader.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_z1000_cfg_loader;

    localparam int WORD_W = 32;

    logic clk = 1'b0;
    logic R   = 1'b1;
    always #5 clk = ~clk;

    z1000_cfg_loader_if #(.WORD_W(WORD_W)) bus70 ();
    z1000_cfg_loader_if #(.WORD_W(WORD_W)) bus32 ();

    z1000_cfg_loader #(.CHAIN_LEN(70), .WORD_W(WORD_W)) u_dut70 (
        .clk (clk),
        .R   (R),
        .bus (bus70)
    );

    z1000_cfg_loader #(.CHAIN_LEN(32), .WORD_W(WORD_W)) u_dut32 (
        .clk (clk),
        .R   (R),
        .bus (bus32)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Statistics gathered by run70 for the scenario tasks to judge.
    int en_cnt, first_en, last_en, bit_err, commit_cnt, commit_cyc;
    int done_cnt, done_cyc, words_acc, ready_after_full, late_busy;
    int post_abort_active, timed_out, start_busy, start_ready;

    task automatic run70(input int gap, input int abort_at, input bit poke);
        logic [31:0] words [3];
        int  widx, cyc, countdown, end_cyc, abort_cyc;
        bit  hs, release_w2, want;
        words[0] = 32'hA5A5A5A5;
        words[1] = 32'h0F0F0F0F;
        words[2] = 32'hFFFFFFC3;
        en_cnt = 0; first_en = -1; last_en = -1; bit_err = 0;
        commit_cnt = 0; commit_cyc = -1; done_cnt = 0; done_cyc = -1;
        words_acc = 0; ready_after_full = 0; late_busy = 0;
        post_abort_active = 0; timed_out = 0;
        @(negedge clk); bus70.start = 1'b1;
        @(negedge clk); bus70.start = 1'b0;
        start_busy  = int'(bus70.busy);
        start_ready = int'(bus70.in_ready);
        widx = 0; release_w2 = (gap < 0); countdown = -1;
        end_cyc = -1; abort_cyc = -1; cyc = 0;
        bus70.in_valid = 1'b1;
        bus70.in_data  = words[0];
        hs = bus70.in_ready;
        while (end_cyc < 0 || cyc < end_cyc) begin
            @(negedge clk);
            cyc++;
            bus70.start = 1'b0;
            bus70.abort = 1'b0;
            if (hs) begin widx++; words_acc++; end
            if (countdown > 0) countdown--;
            if (countdown == 0) begin release_w2 = 1'b1; countdown = -1; end
            if (bus70.cfg_en) begin
                if (en_cnt >= 70 || bus70.cfg_d !== words[en_cnt / 32][en_cnt % 32]) bit_err++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
                if (en_cnt == 32 && !release_w2) countdown = gap;
                if (poke && en_cnt == 20) bus70.start = 1'b1;
                if (en_cnt == abort_at) begin
                    bus70.abort = 1'b1; abort_cyc = cyc; end_cyc = cyc + 20;
                end
            end
            if (abort_cyc >= 0 && cyc > abort_cyc &&
                (bus70.busy || bus70.cfg_en || bus70.in_ready)) post_abort_active++;
            if (bus70.cfg_commit) begin commit_cnt++; commit_cyc = cyc; end
            if (bus70.done) begin
                done_cnt++; done_cyc = cyc; end_cyc = cyc + 4;
                if (poke) bus70.start = 1'b1;
            end
            if (done_cyc >= 0 && cyc > done_cyc && bus70.busy) late_busy++;
            if (words_acc >= 3 && bus70.in_ready) ready_after_full++;
            want = (widx < 3) && (widx != 1 || release_w2) && (abort_cyc < 0);
            bus70.in_valid = want;
            bus70.in_data  = (widx < 3) ? words[widx] : 32'h0;
            hs = want && bus70.in_ready;
            if (cyc >= 400) begin timed_out = 1; break; end
        end
        bus70.in_valid = 1'b0;
        bus70.start    = 1'b0;
        bus70.abort    = 1'b0;
    endtask

    task automatic test_reset();
        #2 R = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus70.in_ready, bus70.cfg_en, bus70.cfg_d, bus70.cfg_commit, bus70.busy, bus70.done} !== 6'b0) begin
            n_errors++; $display("FAIL reset_outputs70 got %b exp 000000",
                {bus70.in_ready, bus70.cfg_en, bus70.cfg_d, bus70.cfg_commit, bus70.busy, bus70.done});
        end
        n_checks++;
        if ({bus32.in_ready, bus32.cfg_en, bus32.cfg_d, bus32.cfg_commit, bus32.busy, bus32.done} !== 6'b0) begin
            n_errors++; $display("FAIL reset_outputs32 got %b exp 000000",
                {bus32.in_ready, bus32.cfg_en, bus32.cfg_d, bus32.cfg_commit, bus32.busy, bus32.done});
        end
        R = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus70.busy !== 1'b0 || bus70.in_ready !== 1'b0) begin
            n_errors++; $display("FAIL idle_after_release busy=%b in_ready=%b exp 0 0", bus70.busy, bus70.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        run70(-1, 0, 1'b0);
        n_checks++; if (start_busy != 1 || start_ready != 1) begin n_errors++;
            $display("FAIL b2b_start_latency busy=%0d in_ready=%0d exp 1 1", start_busy, start_ready); end
        n_checks++; if (en_cnt != 70) begin n_errors++; $display("FAIL b2b_en_count got %0d exp 70", en_cnt); end
        n_checks++; if (bit_err != 0) begin n_errors++; $display("FAIL b2b_bit_order got %0d bad bits exp 0", bit_err); end
        n_checks++; if (first_en != 1) begin n_errors++; $display("FAIL b2b_first_bit_cycle got %0d exp 1", first_en); end
        n_checks++; if (last_en - first_en + 1 != 70) begin n_errors++;
            $display("FAIL b2b_contiguous span got %0d exp 70", last_en - first_en + 1); end
        n_checks++; if (words_acc != 3 || ready_after_full != 0) begin n_errors++;
            $display("FAIL b2b_in_ready_drop words=%0d ready_after=%0d exp 3 0", words_acc, ready_after_full); end
        n_checks++; if (commit_cnt != 1 || commit_cyc != last_en + 1) begin n_errors++;
            $display("FAIL b2b_commit count=%0d cyc=%0d exp 1 %0d", commit_cnt, commit_cyc, last_en + 1); end
        n_checks++; if (done_cnt != 1 || done_cyc != last_en + 2) begin n_errors++;
            $display("FAIL b2b_done count=%0d cyc=%0d exp 1 %0d", done_cnt, done_cyc, last_en + 2); end
        n_checks++; if (late_busy != 0 || timed_out != 0) begin n_errors++;
            $display("FAIL b2b_busy_clear late_busy=%0d timeout=%0d exp 0 0", late_busy, timed_out); end
    endtask

    task automatic test_underrun();
        run70(10, 0, 1'b0);
        n_checks++; if (en_cnt != 70) begin n_errors++; $display("FAIL underrun_en_count got %0d exp 70", en_cnt); end
        n_checks++; if (bit_err != 0) begin n_errors++; $display("FAIL underrun_bit_order got %0d bad bits exp 0", bit_err); end
        n_checks++; if ((last_en - first_en + 1) - en_cnt != 10) begin n_errors++;
            $display("FAIL underrun_gap got %0d idle cycles exp 10", (last_en - first_en + 1) - en_cnt); end
        n_checks++; if (commit_cnt != 1 || commit_cyc != last_en + 1 || done_cyc != last_en + 2) begin n_errors++;
            $display("FAIL underrun_commit count=%0d cyc=%0d done=%0d last=%0d", commit_cnt, commit_cyc, done_cyc, last_en); end
    endtask

    task automatic test_abort();
        run70(-1, 40, 1'b0);
        n_checks++; if (en_cnt != 40) begin n_errors++; $display("FAIL abort_en_count got %0d exp 40", en_cnt); end
        n_checks++; if (commit_cnt != 0 || done_cnt != 0) begin n_errors++;
            $display("FAIL abort_no_pulse commit=%0d done=%0d exp 0 0", commit_cnt, done_cnt); end
        n_checks++; if (post_abort_active != 0 || timed_out != 0) begin n_errors++;
            $display("FAIL abort_idle active_cycles=%0d timeout=%0d exp 0 0", post_abort_active, timed_out); end
        run70(-1, 0, 1'b0);
        n_checks++; if (en_cnt != 70 || bit_err != 0 || commit_cnt != 1 || done_cnt != 1) begin n_errors++;
            $display("FAIL abort_reload en=%0d err=%0d commit=%0d done=%0d exp 70 0 1 1", en_cnt, bit_err, commit_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int seen, bad;
        seen = 0; bad = 0;
        @(negedge clk); bus70.start = 1'b1;
        @(negedge clk); bus70.start = 1'b0;
        bus70.in_valid = 1'b1;
        bus70.in_data  = 32'h3C3C3C3C;
        for (int i = 0; i < 60 && seen < 10; i++) begin
            @(negedge clk);
            if (bus70.cfg_en) seen++;
        end
        n_checks++; if (seen != 10) begin n_errors++; $display("FAIL rstmid_shifting got %0d bits exp 10", seen); end
        R = 1'b0;
        #1;
        n_checks++;
        if ({bus70.in_ready, bus70.cfg_en, bus70.cfg_d, bus70.cfg_commit, bus70.busy, bus70.done} !== 6'b0) begin
            n_errors++; $display("FAIL rstmid_outputs got %b exp 000000",
                {bus70.in_ready, bus70.cfg_en, bus70.cfg_d, bus70.cfg_commit, bus70.busy, bus70.done});
        end
        bus70.in_valid = 1'b0;
        @(negedge clk); R = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus70.busy || bus70.cfg_en || bus70.in_ready || bus70.cfg_commit || bus70.done) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rstmid_stays_idle got %0d active cycles exp 0", bad); end
    endtask

    task automatic test_start_ignored();
        run70(-1, 0, 1'b1);
        n_checks++; if (en_cnt != 70 || bit_err != 0) begin n_errors++;
            $display("FAIL start_ignored_stream en=%0d err=%0d exp 70 0", en_cnt, bit_err); end
        n_checks++; if (commit_cnt != 1 || done_cnt != 1) begin n_errors++;
            $display("FAIL start_ignored_pulses commit=%0d done=%0d exp 1 1", commit_cnt, done_cnt); end
        n_checks++; if (late_busy != 0) begin n_errors++;
            $display("FAIL start_in_done_ignored got %0d busy cycles exp 0", late_busy); end
    endtask

    task automatic test_start_abort_idle();
        int bad;
        bad = 0;
        @(negedge clk); bus70.start = 1'b1; bus70.abort = 1'b1;
        @(negedge clk); bus70.start = 1'b0; bus70.abort = 1'b0;
        n_checks++; if (bus70.busy !== 1'b0 || bus70.in_ready !== 1'b0) begin n_errors++;
            $display("FAIL start_abort_idle busy=%b in_ready=%b exp 0 0", bus70.busy, bus70.in_ready); end
        repeat (5) begin
            @(negedge clk);
            if (bus70.busy || bus70.cfg_en) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL start_abort_stays got %0d active cycles exp 0", bad); end
    endtask

    task automatic test_single_word();
        logic [31:0] w [3];
        int  idx, acc, en, err, cm, dn, first, last;
        bit  hs;
        w[0] = 32'h1234ABCD; w[1] = 32'hDEADBEEF; w[2] = 32'h5A5A0F0F;
        idx = 0; acc = 0; en = 0; err = 0; cm = 0; dn = 0; first = -1; last = -1;
        @(negedge clk); bus32.start = 1'b1;
        @(negedge clk); bus32.start = 1'b0;
        bus32.in_valid = 1'b1;
        bus32.in_data  = w[0];
        hs = bus32.in_ready;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (hs) begin
                acc++;
                if (idx < 2) idx++;
                bus32.in_data = w[idx];
            end
            if (bus32.cfg_en) begin
                if (en >= 32 || bus32.cfg_d !== w[0][en]) err++;
                if (first < 0) first = c;
                last = c;
                en++;
            end
            if (bus32.cfg_commit) cm++;
            if (bus32.done) dn++;
            hs = bus32.in_valid && bus32.in_ready;
        end
        n_checks++; if (acc != 1) begin n_errors++; $display("FAIL single_words_accepted got %0d exp 1", acc); end
        n_checks++; if (en != 32 || err != 0) begin n_errors++;
            $display("FAIL single_stream en=%0d err=%0d exp 32 0", en, err); end
        n_checks++; if (last - first + 1 != 32) begin n_errors++;
            $display("FAIL single_contiguous span got %0d exp 32", last - first + 1); end
        n_checks++; if (cm != 1 || dn != 1 || bus32.busy !== 1'b0 || bus32.in_ready !== 1'b0) begin n_errors++;
            $display("FAIL single_finish commit=%0d done=%0d busy=%b in_ready=%b exp 1 1 0 0", cm, dn, bus32.busy, bus32.in_ready); end
        bus32.in_valid = 1'b0;
    endtask

    initial begin
        bus70.start = 1'b0; bus70.abort = 1'b0; bus70.in_valid = 1'b0; bus70.in_data = '0;
        bus32.start = 1'b0; bus32.abort = 1'b0; bus32.in_valid = 1'b0; bus32.in_data = '0;
        test_reset();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_start_abort_idle();
        test_single_word();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/z1000_cfg_loader.md
# z1000_cfg_loader

Configuration-chain load controller for the z1000 fabric. It accepts configuration words over a valid/ready stream and serialises them LSB-first into a configuration shift chain built from dffe cells. It drives the chain data and chain shift-enable, counts bits to a fixed chain length, then issues a single commit pulse that latches the shadow registers. It sits between the bitstream source and the fabric configuration chain.

## Interface
- CHAIN_LEN, default 1024: number of bits in the configuration chain; must be >= 1.
- WORD_W, default 32: input word width; must be >= 2.
- clk  in  1  clock; all state changes on its rising edge.
- R  in  1  asynchronous reset, active-low; the same reset convention as the dffr/dffer cells.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  cancels the load; takes priority over every other input except R.
- in_valid  in  1  input word valid.
- in_data  in  WORD_W  configuration word; bit 0 is shifted first.
- in_ready  out  1  controller accepts in_data this cycle.
- cfg_en  out  1  chain shift enable, drives E of the chain dffe cells.
- cfg_d  out  1  serial chain data; valid when cfg_en=1.
- cfg_commit  out  1  one-cycle pulse that latches the shadow registers.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.

## Operation
- Derived constant NWORDS = ceil(CHAIN_LEN/WORD_W).
- bit_cnt width is clog2(CHAIN_LEN+1). word_cnt width is clog2(NWORDS+1).
- FSM states: IDLE, LOAD, COMMIT, DONE.
- IDLE -> LOAD on start. On this transition bit_cnt and word_cnt are cleared, and the shifter and holding register are emptied.
- LOAD datapath: a WORD_W shifter plus a one-word holding register, which gives double buffering.
- in_ready is asserted when all three hold: state=LOAD, the holding register is empty, and word_cnt < NWORDS.
- A word is accepted when in_valid & in_ready; word_cnt then increments.
- Where the accepted word goes at the end of the handshake cycle:
  - into the shifter if the shifter is empty or is shifting its final bit that cycle;
  - otherwise into the holding register.
- When the shifter empties and the holding register is full, the holding register transfers to the shifter with no gap cycle.
- While the shifter holds bits and bit_cnt < CHAIN_LEN, each cycle:
  - cfg_en=1 and cfg_d=shifter[0];
  - the shifter shifts right;
  - bit_cnt increments.
- A word holds WORD_W bits. In the last word only CHAIN_LEN - (NWORDS-1)*WORD_W bits are shifted; its upper bits are discarded and never appear with cfg_en=1.
- Underrun (shifter empty, nothing buffered, bit_cnt < CHAIN_LEN): cfg_en=0 and the controller waits. No error is raised and no bits are lost.
- LOAD -> COMMIT on the cycle after the shift that makes bit_cnt=CHAIN_LEN.
- COMMIT: cfg_commit=1 for exactly one cycle, then -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- abort in any state:
  - next state is IDLE and the buffers are emptied;
  - no cfg_commit or done pulse is issued;
  - cfg_en=0 from the next cycle onward.
- start is ignored outside IDLE. start and abort together in IDLE: abort wins and the controller stays in IDLE.
- in_valid while in_ready=0 is ignored; the data is not consumed.

## Timing
- Reset values, all asynchronous on R=0: state=IDLE; in_ready, cfg_en, cfg_d, cfg_commit, busy and done are all 0; all counters and buffers are cleared.
- R asserted mid-load abandons the load immediately, with the same result as reset. No commit is issued.
- start sampled at cycle t gives busy=1 and in_ready=1 at cycle t+1.
- Word accepted at cycle a into an empty shifter: its bits appear with cfg_en=1 in cycles a+1 .. a+WORD_W.
- Sustained throughput is one word per WORD_W cycles with no cfg_en bubbles, provided each next word is accepted before the shifter empties.
- Last shift at cycle s: cfg_commit=1 at s+1, done=1 at s+2, busy=0 at s+3.
- Outputs are registered except in_ready, which is a combinational decode of registered state only.

## Test plan
- CHAIN_LEN=70, WORD_W=32, back-to-back words 0xA5A5A5A5, 0x0F0F0F0F, 0xFFFFFFC3:
  - exactly 70 contiguous cfg_en cycles;
  - cfg_d sequence equals bits 0..69 of the concatenated words;
  - in_ready drops after 3 words;
  - cfg_commit one cycle after the last shift, done the cycle after that.
- Underrun: second word delivered 10 cycles after the first word finishes shifting -> cfg_en low for exactly those gap cycles, bit order intact, total cfg_en count still 70.
- abort asserted after 40 shifted bits -> IDLE next cycle, cfg_en=0 thereafter, no cfg_commit or done pulse, and a new start completes a normal load.
- R pulsed low mid-shift -> all outputs 0 immediately; after release the block stays IDLE until start.
- start pulsed during LOAD and again in DONE -> ignored, single commit/done. start+abort together in IDLE -> stays IDLE.
- CHAIN_LEN=32, WORD_W=32, in_valid held high with 3 words queued -> exactly 1 word consumed, 32 cfg_en cycles, remaining words not accepted.
